// File: rtl/me_frame_scheduler.sv
// me_frame_scheduler: walks every macroblock of a frame in raster order,
// computes template-block and search-window origins, runs one req/ack
// transaction per MB with the ME core and forwards the result on a
// valid/ready stream.
// Optional feature: define ME_SCHED_SADSUM_EN to add the sad_sum output,
// a saturating per-frame sum of accepted min SADs.
module me_frame_scheduler #(
  parameter int FRAME_W_MB  = 6,
  parameter int FRAME_H_MB  = 5,
  parameter int TB_LENGTH   = 16,
  parameter int SW_LENGTH   = 64,
  parameter int SAD_WIDTH   = 16,
  parameter int MVEC_WIDTH  = 12,
  parameter int COORD_WIDTH = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   me_req,
  input  logic                   me_ack,
  input  logic [SAD_WIDTH-1:0]   me_min_sad,
  input  logic [MVEC_WIDTH-1:0]  me_min_mvec,
  output logic [COORD_WIDTH-1:0] tb_x,
  output logic [COORD_WIDTH-1:0] tb_y,
  output logic [COORD_WIDTH-1:0] sw_x,
  output logic [COORD_WIDTH-1:0] sw_y,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [7:0]             res_mb_x,
  output logic [7:0]             res_mb_y,
  output logic [SAD_WIDTH-1:0]   res_sad,
  output logic [MVEC_WIDTH-1:0]  res_mvec
`ifdef ME_SCHED_SADSUM_EN
  ,
  output logic [SAD_WIDTH+7:0]   sad_sum
`endif
);

  typedef enum logic [2:0] {
    IDLE, SETUP, REQ, RELEASE, OUT, NEXT, DONE
  } state_t;

  // Search window is centred on the MB, then pushed back inside the frame.
  localparam logic [COORD_WIDTH-1:0] SW_OFF   = COORD_WIDTH'((SW_LENGTH - TB_LENGTH) / 2);
  localparam logic [COORD_WIDTH-1:0] SW_MAX_X = COORD_WIDTH'(FRAME_W_MB * TB_LENGTH - SW_LENGTH);
  localparam logic [COORD_WIDTH-1:0] SW_MAX_Y = COORD_WIDTH'(FRAME_H_MB * TB_LENGTH - SW_LENGTH);
  localparam logic [7:0]             MB_X_LAST = 8'(FRAME_W_MB - 1);
  localparam logic [7:0]             MB_Y_LAST = 8'(FRAME_H_MB - 1);

  state_t                 state;
  logic [7:0]             mb_x, mb_y;
  logic [COORD_WIDTH-1:0] tb_x_c, tb_y_c;
  logic                   last_mb;

  // Subtract in one extra signed bit so MBs near the top/left clamp to 0.
  function automatic logic [COORD_WIDTH-1:0] sw_clamp(
    input logic [COORD_WIDTH-1:0] t,
    input logic [COORD_WIDTH-1:0] maxv
  );
    logic signed [COORD_WIDTH:0] d;
    d = $signed({1'b0, t}) - $signed({1'b0, SW_OFF});
    if (d < 0)                          return '0;
    else if (d > $signed({1'b0, maxv})) return maxv;
    else                                return d[COORD_WIDTH-1:0];
  endfunction

  assign tb_x_c  = COORD_WIDTH'(mb_x) * COORD_WIDTH'(TB_LENGTH);
  assign tb_y_c  = COORD_WIDTH'(mb_y) * COORD_WIDTH'(TB_LENGTH);
  assign last_mb = (mb_x == MB_X_LAST) && (mb_y == MB_Y_LAST);

`ifdef ME_SCHED_SADSUM_EN
  logic [SAD_WIDTH+8:0] sum_ext;
  assign sum_ext = {1'b0, sad_sum} + {9'd0, res_sad};
`endif

  // Frame sequencer; every output is registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      me_req     <= 1'b0;
      res_valid  <= 1'b0;
      mb_x       <= '0;
      mb_y       <= '0;
      tb_x       <= '0;
      tb_y       <= '0;
      sw_x       <= '0;
      sw_y       <= '0;
      res_sad    <= '1;
      res_mvec   <= '0;
      res_mb_x   <= '0;
      res_mb_y   <= '0;
`ifdef ME_SCHED_SADSUM_EN
      sad_sum    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          mb_x <= '0;
          mb_y <= '0;
          if (start) begin
            state <= SETUP;
            busy  <= 1'b1;
`ifdef ME_SCHED_SADSUM_EN
            sad_sum <= '0;
`endif
          end
        end
        SETUP: begin
          tb_x   <= tb_x_c;
          tb_y   <= tb_y_c;
          sw_x   <= sw_clamp(tb_x_c, SW_MAX_X);
          sw_y   <= sw_clamp(tb_y_c, SW_MAX_Y);
          me_req <= 1'b1;
          state  <= REQ;
        end
        REQ: begin
          if (me_ack) begin
            res_sad  <= me_min_sad;
            res_mvec <= me_min_mvec;
            res_mb_x <= mb_x;
            res_mb_y <= mb_y;
            me_req   <= 1'b0;
            state    <= RELEASE;
          end
        end
        RELEASE: begin
          // Core holds ack until it sees req low; wait it out before output.
          if (!me_ack) begin
            res_valid <= 1'b1;
            state     <= OUT;
          end
        end
        OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
`ifdef ME_SCHED_SADSUM_EN
            sad_sum <= sum_ext[SAD_WIDTH+8] ? '1 : sum_ext[SAD_WIDTH+7:0];
`endif
            if (last_mb) begin
              frame_done <= 1'b1;
              state      <= DONE;
            end else begin
              state <= NEXT;
            end
          end
        end
        NEXT: begin
          if (mb_x == MB_X_LAST) begin
            mb_x <= '0;
            mb_y <= mb_y + 8'd1;
          end else begin
            mb_x <= mb_x + 8'd1;
          end
          state <= SETUP;
        end
        DONE: begin
          frame_done <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_me_frame_scheduler.sv
// tb_me_frame_scheduler: randomized bench with a behavioural ME core and a
// raster-order reference of expected origins, results and SAD sums.
module tb_me_frame_scheduler;
  localparam int FW = 6, FH = 5, TBL = 16, SWL = 64, SADW = 16, MVW = 12, CW = 12;
  localparam int NMB = FW * FH;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, res_ready = 1'b1;
  logic me_ack = 1'b0;
  logic [SADW-1:0] me_min_sad = '0;
  logic [MVW-1:0]  me_min_mvec = '0;
  logic busy, frame_done, me_req, res_valid;
  logic [CW-1:0] tb_x, tb_y, sw_x, sw_y;
  logic [7:0] res_mb_x, res_mb_y;
  logic [SADW-1:0] res_sad;
  logic [MVW-1:0] res_mvec;
`ifdef ME_SCHED_SADSUM_EN
  logic [SADW+7:0] sad_sum;
`endif

  me_frame_scheduler #(.FRAME_W_MB(FW), .FRAME_H_MB(FH), .TB_LENGTH(TBL), .SW_LENGTH(SWL),
    .SAD_WIDTH(SADW), .MVEC_WIDTH(MVW), .COORD_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .frame_done(frame_done),
    .me_req(me_req), .me_ack(me_ack), .me_min_sad(me_min_sad), .me_min_mvec(me_min_mvec),
    .tb_x(tb_x), .tb_y(tb_y), .sw_x(sw_x), .sw_y(sw_y),
    .res_valid(res_valid), .res_ready(res_ready), .res_mb_x(res_mb_x), .res_mb_y(res_mb_y),
    .res_sad(res_sad), .res_mvec(res_mvec)
`ifdef ME_SCHED_SADSUM_EN
    , .sad_sum(sad_sum)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference origin: centred window clamped into the frame.
  function automatic int sw_ref(input int t, input int maxv);
    int v;
    v = t - (SWL - TBL) / 2;
    if (v < 0) v = 0;
    if (v > maxv) v = maxv;
    return v;
  endfunction

  typedef struct { int mx; int my; int sad; int mvec; } exp_t;
  exp_t exp_q[$];

  // Knobs set by the main sequence.
  int lat_fix = 10;    // <0: random latency
  int hold_val = 0;    // <0: random hold
  int sad_mode = 0;    // 0 random, 1 fixed 0x123/0x2A5, 2 all 100, 3 all 0xFFFF

  // Model state.
  int req_idx = 0, cst = 0, cnt = 0, cur_mx = 0, cur_my = 0;
  int res_cnt = 0, done_cnt = 0;
  longint sum_ref = 0;
  logic prev_fd = 1'b0;

  // Result monitor first, then the behavioural ME core.
  always @(negedge clk) begin
    exp_t e;
    int s, m;
    if (rst) begin
      me_ack = 1'b0; cst = 0; req_idx = 0; exp_q.delete();
      res_cnt = 0; sum_ref = 0; prev_fd = 1'b0;
    end else begin
      if (res_valid) begin
        chk("ack_low_in_out", 32'(me_ack), 0);
        chk("req_low_in_out", 32'(me_req), 0);
        if (exp_q.size() == 0) chk("res_unexpected", 1, 0);
        else begin
          e = exp_q[0];
          chk("res_mb_x", 32'(res_mb_x), e.mx);
          chk("res_mb_y", 32'(res_mb_y), e.my);
          chk("res_sad", 32'(res_sad), e.sad);
          chk("res_mvec", 32'(res_mvec), e.mvec);
          if (res_ready) begin
            void'(exp_q.pop_front());
            res_cnt++;
            sum_ref = sum_ref + e.sad;
            if (sum_ref > 64'(2**24 - 1)) sum_ref = 2**24 - 1;
          end
        end
      end
      if (frame_done) begin
        done_cnt++;
        chk("fd_pulse", 32'(prev_fd), 0);
        chk("res_count", res_cnt, NMB);
        chk("busy_in_done", 32'(busy), 1);
`ifdef ME_SCHED_SADSUM_EN
        chk("sad_sum", 32'(sad_sum), 32'(sum_ref));
`endif
        res_cnt = 0; sum_ref = 0;
      end
      prev_fd = frame_done;

      case (cst)
        0: if (me_req) begin
          cur_mx = req_idx % FW; cur_my = req_idx / FW;
          req_idx = (req_idx + 1) % NMB;
          chk("tb_x", 32'(tb_x), cur_mx * TBL);
          chk("tb_y", 32'(tb_y), cur_my * TBL);
          chk("sw_x", 32'(sw_x), sw_ref(cur_mx * TBL, FW * TBL - SWL));
          chk("sw_y", 32'(sw_y), sw_ref(cur_my * TBL, FH * TBL - SWL));
          cnt = (lat_fix < 0) ? int'($urandom_range(0, 12)) : lat_fix;
          cst = 1;
        end
        1: if (cnt == 0) begin
          case (sad_mode)
            1: begin s = 'h0123; m = 'h2A5; end
            2: begin s = 100; m = int'($urandom_range(0, 4095)); end
            3: begin s = 'hFFFF; m = int'($urandom_range(0, 4095)); end
            default: begin s = int'($urandom_range(0, 'hFFFF)); m = int'($urandom_range(0, 4095)); end
          endcase
          me_ack = 1'b1; me_min_sad = SADW'(s); me_min_mvec = MVW'(m);
          exp_q.push_back('{cur_mx, cur_my, s, m});
          cst = 2;
        end else cnt--;
        2: if (!me_req) begin
          cnt = (hold_val < 0) ? int'($urandom_range(0, 3)) : hold_val;
          if (cnt == 0) begin me_ack = 1'b0; cst = 0; end
          else begin cnt--; cst = 3; end
        end
        3: begin
          chk("req_reassert", 32'(me_req), 0);
          if (cnt == 0) begin me_ack = 1'b0; cst = 0; end else cnt--;
        end
        default: cst = 0;
      endcase
    end
  end

  task automatic check_reset();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_me_req", 32'(me_req), 0);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_tb_x", 32'(tb_x), 0);
    chk("rst_tb_y", 32'(tb_y), 0);
    chk("rst_sw_x", 32'(sw_x), 0);
    chk("rst_sw_y", 32'(sw_y), 0);
    chk("rst_res_sad", 32'(res_sad), 'hFFFF);
    chk("rst_res_mvec", 32'(res_mvec), 0);
    chk("rst_res_mb_x", 32'(res_mb_x), 0);
    chk("rst_res_mb_y", 32'(res_mb_y), 0);
  endtask

  // Pulse start, check launch latency, then run the frame to frame_done.
  task automatic run_frame(input bit rnd_ready, input bit bp);
    int d0;
    bit bp_done, ok;
    d0 = done_cnt; bp_done = 0; ok = 0;
    res_ready = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("busy_after_start", 32'(busy), 1);
    chk("req_cycle1", 32'(me_req), 0);
    @(posedge clk); #1;
    chk("req_cycle2", 32'(me_req), 1);
    for (int c = 0; c < 6000; c++) begin
      @(posedge clk); #1;
      if (bp && !bp_done && res_valid) begin
        res_ready = 1'b0;
        repeat (20) begin @(posedge clk); #1; end
        chk("bp_valid_held", 32'(res_valid), 1);
        res_ready = 1'b1; bp_done = 1;
      end else if (rnd_ready) res_ready = 1'($urandom_range(0, 1));
      if (done_cnt != d0) begin ok = 1; break; end
    end
    chk("frame_timeout", 32'(ok), 1);
    res_ready = 1'b1;
    @(posedge clk); #1;
    chk("busy_after_frame", 32'(busy), 0);
    chk("frame_done_once", done_cnt - d0, 1);
  endtask

  initial begin
    int d0;
    bit ok;
    repeat (3) @(posedge clk);
    #1 check_reset();
    rst = 1'b0;

    lat_fix = 10; hold_val = 0; sad_mode = 0;
    run_frame(0, 0);

    lat_fix = 4; hold_val = 3; sad_mode = 1;
    run_frame(0, 0);

    lat_fix = -1; hold_val = -1; sad_mode = 0;
    run_frame(1, 1);

    // Mid-frame reset at MB 7 while the request is outstanding.
    lat_fix = 10; hold_val = 0; sad_mode = 0;
    d0 = done_cnt; ok = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int c = 0; c < 2000 && !ok; c++) begin
      @(posedge clk); #1;
      if (req_idx >= 3 && busy) ok = 1;
    end
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    ok = 0;
    for (int c = 0; c < 2000 && !ok; c++) begin
      @(posedge clk); #1;
      if (req_idx == 8 && me_req && !me_ack) ok = 1;
    end
    chk("reach_mb7_req", 32'(ok), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset();
    rst = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    chk("no_done_after_rst", done_cnt - d0, 0);
    chk("idle_after_rst", 32'(busy), 0);

    lat_fix = -1; hold_val = 0; sad_mode = 2;
    run_frame(0, 0);

    lat_fix = 2; hold_val = 1; sad_mode = 3;
    run_frame(0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
